// File: rtl/multicycle_control_p.sv
// ---------------------------------------------------------------------------
// multicycle_control_p
//
// Control unit for a multicycle MIPS-subset datapath. A Moore FSM sequences
// fetch, decode, execute, memory and write-back for R-type ALU ops
// (ADD/SUB/AND/XOR), LW, SW, BEQ, BNE, LUI, J, NOP and BREAK. The memory read
// latency is a parameter. One wait counter covers both memory wait states.
//
// Parameters:
//   MEM_LAT      memory read wait cycles after the address cycle (0..15)
//
// Optional feature (compile-time macro):
//   CTRL_EXCEPTION_EN  defined   : illegal OP/Funct in DECODE enters EXC,
//                                  which redirects PC to the exception vector.
//                      undefined : illegal encodings behave as NOP and
//                                  Exception is tied low.
//
// Ports:
//   Clk          in   clock, rising edge
//   Reset        in   asynchronous active-low reset
//   OP           in   IR[31:26]
//   Funct        in   IR[5:0]
//   Zero         in   ALU zero flag (used in BRANCH only)
//   PCWrite      out  PC load enable (branch-qualified in BRANCH)
//   IorD         out  memory address select: 0 = PC, 1 = ALUOut
//   wr           out  memory write strobe
//   MemtoReg     out  write-data select: 00 ALUOut, 01 MDR, 10 {imm,16'h0}
//   IRWrite_C    out  IR load enable
//   PCSource     out  00 ALU, 01 ALUOut, 10 jump target, 11 exception vector
//   AluOp        out  000 pass A, 001 add, 010 sub, 011 and, 110 xor
//   AluSrcA      out  0 = PC, 1 = A
//   AluSrcB      out  00 B, 01 4, 10 sext(imm), 11 sext(imm)<<2
//   AluOutWrite  out  ALUOut load enable
//   MDRWrite     out  MDR load enable
//   AWrite       out  A register load enable
//   BWrite       out  B register load enable
//   RegWrite_C   out  register-file write enable
//   RegDst       out  destination select: 0 = rt, 1 = rd
//   Halted       out  high while in HALT
//   Exception    out  high while in EXC
//   State        out  current state code
// ---------------------------------------------------------------------------
module multicycle_control_p #(
    parameter int MEM_LAT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] OP,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IorD,
    output logic       wr,
    output logic [1:0] MemtoReg,
    output logic       IRWrite_C,
    output logic [1:0] PCSource,
    output logic [2:0] AluOp,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic       AluOutWrite,
    output logic       MDRWrite,
    output logic       AWrite,
    output logic       BWrite,
    output logic       RegWrite_C,
    output logic       RegDst,
    output logic       Halted,
    output logic       Exception,
    output logic [5:0] State
);

    // Counter must be at least one bit wide even when MEM_LAT is 0.
    localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    // Opcodes and function codes.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_NOP   = 6'h00;
    localparam logic [5:0] FN_BREAK = 6'h0D;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_XOR   = 6'h26;

    typedef enum logic [5:0] {
        S_RESET      = 6'd0,
        S_FETCH      = 6'd1,
        S_FETCH_WAIT = 6'd2,
        S_IR_WRITE   = 6'd3,
        S_DECODE     = 6'd4,
        S_R_EXEC     = 6'd5,
        S_R_WB       = 6'd6,
        S_ADDR       = 6'd7,
        S_MEM_RD     = 6'd8,
        S_MDR_WR     = 6'd9,
        S_LW_WB      = 6'd10,
        S_MEM_WR     = 6'd11,
        S_BRANCH     = 6'd12,
        S_LUI_WB     = 6'd13,
        S_JUMP       = 6'd14,
        S_HALT       = 6'd15,
        S_EXC        = 6'd16,
        S_LD_WAIT    = 6'd17
    } state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;

    // Instruction class predecode from the live IR fields.
    logic is_rtype;
    logic is_r_alu;

    assign is_rtype = (OP == OP_RTYPE);
    assign is_r_alu = is_rtype && ((Funct == FN_ADD) || (Funct == FN_SUB) ||
                                   (Funct == FN_AND) || (Funct == FN_XOR));

    // -----------------------------------------------------------------------
    // State register and wait counter.
    // The counter is loaded with MEM_LAT on entry to a wait state and the
    // wait state is left in the cycle the count reads 1, giving exactly
    // MEM_LAT cycles of waiting.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= S_RESET;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_RESET: state <= S_FETCH;

                S_FETCH: begin
                    if (MEM_LAT > 0) begin
                        state    <= S_FETCH_WAIT;
                        wait_cnt <= LAT_LOAD;
                    end else begin
                        state <= S_IR_WRITE;
                    end
                end

                S_FETCH_WAIT: begin
                    if (wait_cnt == CNT_LAST) state <= S_IR_WRITE;
                    else                      wait_cnt <= wait_cnt - 1'b1;
                end

                S_IR_WRITE: state <= S_DECODE;

                S_DECODE: begin
                    if (is_r_alu) begin
                        state <= S_R_EXEC;
                    end else if (is_rtype && Funct == FN_BREAK) begin
                        state <= S_HALT;
                    end else if (is_rtype && Funct == FN_NOP) begin
                        state <= S_FETCH;
                    end else if (OP == OP_LW || OP == OP_SW) begin
                        state <= S_ADDR;
                    end else if (OP == OP_BEQ || OP == OP_BNE) begin
                        state <= S_BRANCH;
                    end else if (OP == OP_LUI) begin
                        state <= S_LUI_WB;
                    end else if (OP == OP_J) begin
                        state <= S_JUMP;
                    end else begin
`ifdef CTRL_EXCEPTION_EN
                        state <= S_EXC;
`else
                        state <= S_FETCH;
`endif
                    end
                end

                S_R_EXEC: state <= S_R_WB;
                S_R_WB:   state <= S_FETCH;

                S_ADDR: state <= (OP == OP_LW) ? S_MEM_RD : S_MEM_WR;

                S_MEM_RD: begin
                    if (MEM_LAT > 0) begin
                        state    <= S_LD_WAIT;
                        wait_cnt <= LAT_LOAD;
                    end else begin
                        state <= S_MDR_WR;
                    end
                end

                S_LD_WAIT: begin
                    if (wait_cnt == CNT_LAST) state <= S_MDR_WR;
                    else                      wait_cnt <= wait_cnt - 1'b1;
                end

                S_MDR_WR:  state <= S_LW_WB;
                S_LW_WB:   state <= S_FETCH;
                S_MEM_WR:  state <= S_FETCH;
                S_BRANCH:  state <= S_FETCH;
                S_LUI_WB:  state <= S_FETCH;
                S_JUMP:    state <= S_FETCH;
                S_HALT:    state <= S_HALT;
                S_EXC:     state <= S_FETCH;
                default:   state <= S_RESET;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output decode. Outputs depend only on the state register, except
    // PCWrite in BRANCH (Zero) and AluOp in R_EXEC (Funct), both of which
    // are stable IR/ALU fields while those states are active. Reset forces
    // the state to RESET, whose decode is all zeros.
    // -----------------------------------------------------------------------
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        wr          = 1'b0;
        MemtoReg    = 2'b00;
        IRWrite_C   = 1'b0;
        PCSource    = 2'b00;
        AluOp       = 3'b000;
        AluSrcA     = 1'b0;
        AluSrcB     = 2'b00;
        AluOutWrite = 1'b0;
        MDRWrite    = 1'b0;
        AWrite      = 1'b0;
        BWrite      = 1'b0;
        RegWrite_C  = 1'b0;
        RegDst      = 1'b0;
        Halted      = 1'b0;
        Exception   = 1'b0;

        case (state)
            S_FETCH, S_FETCH_WAIT: begin
                AluSrcB = 2'b01;
                AluOp   = 3'b001;
            end

            S_IR_WRITE: begin
                IRWrite_C = 1'b1;
                PCWrite   = 1'b1;
                PCSource  = 2'b00;
                AluSrcB   = 2'b01;
                AluOp     = 3'b001;
            end

            S_DECODE: begin
                // Speculatively computes the branch target into ALUOut.
                AWrite      = 1'b1;
                BWrite      = 1'b1;
                AluSrcB     = 2'b11;
                AluOp       = 3'b001;
                AluOutWrite = 1'b1;
            end

            S_R_EXEC: begin
                AluSrcA     = 1'b1;
                AluSrcB     = 2'b00;
                AluOutWrite = 1'b1;
                case (Funct)
                    FN_ADD:  AluOp = 3'b001;
                    FN_SUB:  AluOp = 3'b010;
                    FN_AND:  AluOp = 3'b011;
                    FN_XOR:  AluOp = 3'b110;
                    default: AluOp = 3'b000;
                endcase
            end

            S_R_WB: begin
                RegDst     = 1'b1;
                RegWrite_C = 1'b1;
            end

            S_ADDR: begin
                AluSrcA     = 1'b1;
                AluSrcB     = 2'b10;
                AluOp       = 3'b001;
                AluOutWrite = 1'b1;
            end

            S_MEM_RD, S_LD_WAIT: IorD = 1'b1;

            S_MDR_WR: begin
                IorD     = 1'b1;
                MDRWrite = 1'b1;
            end

            S_LW_WB: begin
                MemtoReg   = 2'b01;
                RegWrite_C = 1'b1;
            end

            S_MEM_WR: begin
                IorD = 1'b1;
                wr   = 1'b1;
            end

            S_BRANCH: begin
                AluSrcA  = 1'b1;
                AluSrcB  = 2'b00;
                AluOp    = 3'b010;
                PCSource = 2'b01;
                // BEQ (04h) takes on Zero, BNE (05h) on ~Zero; OP[0] tells them apart.
                PCWrite  = OP[0] ? ~Zero : Zero;
            end

            S_LUI_WB: begin
                MemtoReg   = 2'b10;
                RegWrite_C = 1'b1;
            end

            S_JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
            end

            S_HALT: Halted = 1'b1;

`ifdef CTRL_EXCEPTION_EN
            S_EXC: begin
                PCSource  = 2'b11;
                PCWrite   = 1'b1;
                Exception = 1'b1;
            end
`endif

            default: ;
        endcase
    end

    assign State = state;

endmodule

// File: tb/tb_multicycle_control_p.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_p
//
// Bench for multicycle_control_p. Two instances share inputs: one with
// MEM_LAT=2 and one with MEM_LAT=0. For each instruction the expected state
// sequence and per-state outputs are pushed into one queue per instance and
// popped as the instances step. Honours CTRL_EXCEPTION_EN when defined.
// ---------------------------------------------------------------------------
module tb_multicycle_control_p;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       wr;
        logic [1:0] mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_out_write;
        logic       mdr_write;
        logic       a_write;
        logic       b_write;
        logic       reg_write;
        logic       reg_dst;
        logic       halted;
        logic       exception;
    } outs_t;

    typedef struct packed {
        logic [5:0] st;
        outs_t      outs;
    } exp_t;

    typedef enum int {K_R, K_LW, K_SW, K_BR, K_LUI, K_J, K_NOP, K_HALT, K_ILL} kind_e;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [5:0] OP = '0;
    logic [5:0] Funct = '0;
    logic       Zero = 1'b0;

    // MEM_LAT=2 instance outputs
    logic       PCWrite2, IorD2, wr2, IRWrite_C2, AluSrcA2, AluOutWrite2, MDRWrite2;
    logic       AWrite2, BWrite2, RegWrite_C22, RegDst2, Halted2, Exception2;
    logic [1:0] MemtoReg2, PCSource2, AluSrcB2;
    logic [2:0] AluOp2;
    logic [5:0] State2;
    // MEM_LAT=0 instance outputs
    logic       PCWrite0, IorD0, wr0, IRWrite_C0, AluSrcA0, AluOutWrite0, MDRWrite0;
    logic       AWrite0, BWrite0, RegWrite_C0, RegDst0, Halted0, Exception0;
    logic [1:0] MemtoReg0, PCSource0, AluSrcB0;
    logic [2:0] AluOp0;
    logic [5:0] State0;

    outs_t o2, o0;
    assign o2 = {PCWrite2, IorD2, wr2, MemtoReg2, IRWrite_C2, PCSource2, AluOp2, AluSrcA2,
                 AluSrcB2, AluOutWrite2, MDRWrite2, AWrite2, BWrite2, RegWrite_C22, RegDst2,
                 Halted2, Exception2};
    assign o0 = {PCWrite0, IorD0, wr0, MemtoReg0, IRWrite_C0, PCSource0, AluOp0, AluSrcA0,
                 AluSrcB0, AluOutWrite0, MDRWrite0, AWrite0, BWrite0, RegWrite_C0, RegDst0,
                 Halted0, Exception0};

    multicycle_control_p #(.MEM_LAT(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .OP(OP), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite2), .IorD(IorD2), .wr(wr2), .MemtoReg(MemtoReg2),
        .IRWrite_C(IRWrite_C2), .PCSource(PCSource2), .AluOp(AluOp2),
        .AluSrcA(AluSrcA2), .AluSrcB(AluSrcB2), .AluOutWrite(AluOutWrite2),
        .MDRWrite(MDRWrite2), .AWrite(AWrite2), .BWrite(BWrite2),
        .RegWrite_C(RegWrite_C22), .RegDst(RegDst2), .Halted(Halted2),
        .Exception(Exception2), .State(State2)
    );

    multicycle_control_p #(.MEM_LAT(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .OP(OP), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite0), .IorD(IorD0), .wr(wr0), .MemtoReg(MemtoReg0),
        .IRWrite_C(IRWrite_C0), .PCSource(PCSource0), .AluOp(AluOp0),
        .AluSrcA(AluSrcA0), .AluSrcB(AluSrcB0), .AluOutWrite(AluOutWrite0),
        .MDRWrite(MDRWrite0), .AWrite(AWrite0), .BWrite(BWrite0),
        .RegWrite_C(RegWrite_C0), .RegDst(RegDst0), .Halted(Halted0),
        .Exception(Exception0), .State(State0)
    );

    always #5 Clk = ~Clk;

    int   errors = 0;
    int   checks = 0;
    exp_t q2[$];
    exp_t q0[$];

    // Reference output table, one entry per state.
    function automatic outs_t exp_outs(input logic [5:0] st, input logic [5:0] op,
                                       input logic [5:0] fn, input logic zero);
        outs_t o;
        o = '0;
        case (st)
            6'd1, 6'd2: begin o.alu_src_b = 2'b01; o.alu_op = 3'b001; end
            6'd3: begin
                o.ir_write = 1; o.pc_write = 1; o.alu_src_b = 2'b01; o.alu_op = 3'b001;
            end
            6'd4: begin
                o.a_write = 1; o.b_write = 1; o.alu_src_b = 2'b11; o.alu_op = 3'b001;
                o.alu_out_write = 1;
            end
            6'd5: begin
                o.alu_src_a = 1; o.alu_out_write = 1;
                if (fn == 6'h20) o.alu_op = 3'b001;
                else if (fn == 6'h22) o.alu_op = 3'b010;
                else if (fn == 6'h24) o.alu_op = 3'b011;
                else if (fn == 6'h26) o.alu_op = 3'b110;
            end
            6'd6: begin o.reg_dst = 1; o.reg_write = 1; end
            6'd7: begin
                o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 3'b001; o.alu_out_write = 1;
            end
            6'd8, 6'd17: o.iord = 1;
            6'd9: begin o.iord = 1; o.mdr_write = 1; end
            6'd10: begin o.mem_to_reg = 2'b01; o.reg_write = 1; end
            6'd11: begin o.iord = 1; o.wr = 1; end
            6'd12: begin
                o.alu_src_a = 1; o.alu_op = 3'b010; o.pc_source = 2'b01;
                o.pc_write = (op == 6'h04) ? zero : ~zero;
            end
            6'd13: begin o.mem_to_reg = 2'b10; o.reg_write = 1; end
            6'd14: begin o.pc_source = 2'b10; o.pc_write = 1; end
            6'd15: o.halted = 1;
            6'd16: begin o.pc_source = 2'b11; o.pc_write = 1; o.exception = 1; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic push_one(input int lat, input logic [5:0] st);
        exp_t e;
        e.st   = st;
        e.outs = exp_outs(st, OP, Funct, Zero);
        if (lat == 2) q2.push_back(e);
        else          q0.push_back(e);
    endtask

    // Expected trajectory from the reset cycle through one instruction.
    task automatic push_seq(input int lat, input kind_e kind, input bit ret_fetch);
        push_one(lat, 6'd0);
        push_one(lat, 6'd1);
        for (int i = 0; i < lat; i++) push_one(lat, 6'd2);
        push_one(lat, 6'd3);
        push_one(lat, 6'd4);
        case (kind)
            K_R:   begin push_one(lat, 6'd5); push_one(lat, 6'd6); end
            K_LW: begin
                push_one(lat, 6'd7); push_one(lat, 6'd8);
                for (int i = 0; i < lat; i++) push_one(lat, 6'd17);
                push_one(lat, 6'd9); push_one(lat, 6'd10);
            end
            K_SW:   begin push_one(lat, 6'd7); push_one(lat, 6'd11); end
            K_BR:   push_one(lat, 6'd12);
            K_LUI:  push_one(lat, 6'd13);
            K_J:    push_one(lat, 6'd14);
            K_HALT: push_one(lat, 6'd15);
            K_ILL: begin
`ifdef CTRL_EXCEPTION_EN
                push_one(lat, 6'd16);
`endif
            end
            default: ;
        endcase
        if (ret_fetch) push_one(lat, 6'd1);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        @(posedge Clk);
        #1 Reset = 1'b1;
    endtask

    // Step both instances, popping and comparing until both queues drain.
    task automatic run_queues(input string name);
        exp_t e;
        int   step = 0;
        while ((q2.size() > 0 || q0.size() > 0) && step < 200) begin
            @(negedge Clk);
            if (q2.size() > 0) begin
                e = q2.pop_front();
                checks++;
                if (State2 !== e.st || o2 !== e.outs) begin
                    errors++;
                    $display("FAIL %s lat2 step%0d: got state=%0d outs=%h, expected state=%0d outs=%h",
                             name, step, State2, o2, e.st, e.outs);
                end
            end
            if (q0.size() > 0) begin
                e = q0.pop_front();
                checks++;
                if (State0 !== e.st || o0 !== e.outs) begin
                    errors++;
                    $display("FAIL %s lat0 step%0d: got state=%0d outs=%h, expected state=%0d outs=%h",
                             name, step, State0, o0, e.st, e.outs);
                end
            end
            step++;
        end
        checks++;
        if (q2.size() != 0 || q0.size() != 0) begin
            errors++;
            $display("FAIL %s timeout: %0d/%0d entries left, expected 0", name, q2.size(), q0.size());
            q2.delete();
            q0.delete();
        end
    endtask

    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic zero, input kind_e kind);
        OP = op; Funct = fn; Zero = zero;
        push_seq(2, kind, 1'b1);
        push_seq(0, kind, 1'b1);
        do_reset();
        run_queues(name);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        OP = 6'h23; Funct = 6'h20; Zero = 1'b1;
        repeat (2) @(negedge Clk);
        checks++;
        if (State2 !== 6'd0 || o2 !== '0 || State0 !== 6'd0 || o0 !== '0) begin
            errors++;
            $display("FAIL reset_state: got %0d/%h %0d/%h, expected 0/0 0/0", State2, o2, State0, o0);
        end
    endtask

    task automatic test_rtype();
        run_instr("add", 6'h00, 6'h20, 1'b0, K_R);
        run_instr("sub", 6'h00, 6'h22, 1'b1, K_R);
        run_instr("and", 6'h00, 6'h24, 1'b0, K_R);
        run_instr("xor", 6'h00, 6'h26, 1'b0, K_R);
    endtask

    task automatic test_load();
        run_instr("lw", 6'h23, 6'h15, 1'b0, K_LW);
    endtask

    task automatic test_branch();
        run_instr("beq_z1", 6'h04, 6'h00, 1'b1, K_BR);
        run_instr("bne_z1", 6'h05, 6'h00, 1'b1, K_BR);
        run_instr("beq_z0", 6'h04, 6'h00, 1'b0, K_BR);
        run_instr("bne_z0", 6'h05, 6'h00, 1'b0, K_BR);
    endtask

    task automatic test_misc();
        run_instr("lui", 6'h0F, 6'h3A, 1'b0, K_LUI);
        run_instr("j",   6'h02, 6'h11, 1'b0, K_J);
        run_instr("nop", 6'h00, 6'h00, 1'b0, K_NOP);
        run_instr("sw",  6'h2B, 6'h00, 1'b0, K_SW);
    endtask

    task automatic test_illegal();
        run_instr("ill_op3f", 6'h3F, 6'h00, 1'b0, K_ILL);
        run_instr("ill_funct", 6'h00, 6'h3C, 1'b0, K_ILL);
    endtask

    // SW aborted by reset while the write strobe is high.
    task automatic test_sw_reset_abort();
        OP = 6'h2B; Funct = 6'h00; Zero = 1'b0;
        push_seq(2, K_SW, 1'b0);
        push_seq(0, K_SW, 1'b1);
        do_reset();
        run_queues("sw_abort_seq");
        #1;
        checks++;
        if (State2 !== 6'd11 || wr2 !== 1'b1) begin
            errors++;
            $display("FAIL sw_abort_pre: got state=%0d wr=%b, expected 11/1", State2, wr2);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (State2 !== 6'd0 || wr2 !== 1'b0 || o2 !== '0 || State0 !== 6'd0) begin
            errors++;
            $display("FAIL sw_abort_async: got state=%0d wr=%b outs=%h st0=%0d, expected 0/0/0/0",
                     State2, wr2, o2, State0);
        end
        @(posedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
        checks++;
        if (State2 !== 6'd0) begin
            errors++;
            $display("FAIL sw_abort_reset_cycle: got state=%0d, expected 0", State2);
        end
        @(negedge Clk);
        checks++;
        if (State2 !== 6'd1 || State0 !== 6'd1) begin
            errors++;
            $display("FAIL sw_abort_fetch: got %0d/%0d, expected 1/1", State2, State0);
        end
    endtask

    task automatic test_break_halt();
        OP = 6'h00; Funct = 6'h0D; Zero = 1'b0;
        push_seq(2, K_HALT, 1'b0);
        push_seq(0, K_HALT, 1'b0);
        do_reset();
        run_queues("break");
        for (int i = 0; i < 100; i++) begin
            @(posedge Clk);
            #1;
            OP    = 6'($urandom_range(0, 63));
            Funct = 6'($urandom_range(0, 63));
            Zero  = 1'($urandom_range(0, 1));
            @(negedge Clk);
            checks++;
            if (State2 !== 6'd15 || Halted2 !== 1'b1 || o2 !== exp_outs(6'd15, OP, Funct, Zero) ||
                State0 !== 6'd15 || Halted0 !== 1'b1) begin
                errors++;
                $display("FAIL halt_hold cyc%0d: got %0d/%b %0d/%b, expected 15/1 15/1",
                         i, State2, Halted2, State0, Halted0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load();
        test_branch();
        test_misc();
        test_illegal();
        test_sw_reset_abort();
        test_break_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "time bound exceeded");
    end

endmodule

// File: doc/multicycle_control_p.md
# multicycle_control_p

Parametrised multicycle MIPS-subset control unit, successor to the fixed-latency fetch/decode controller. Drives the datapath enables and mux selects for fetch, decode, execute, memory and write-back. Memory read latency is a parameter. Branches (BEQ/BNE with the `Zero` flag), SW, LUI, J and BREAK are fully sequenced, and illegal encodings can optionally trap.

## Interface
Parameters:
- `MEM_LAT`, default 2: memory read latency in wait cycles after the address cycle; legal range 0..15.

Ports:
- `Clk` in 1: sole clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `OP` in 6: IR[31:26].
- `Funct` in 6: IR[5:0].
- `Zero` in 1: ALU zero flag, same cycle.
- `PCWrite` out 1: PC load enable, already qualified by branch condition.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `wr` out 1: memory write strobe.
- `MemtoReg` out 2: write-data select; 00 = ALUOut, 01 = MDR, 10 = {imm,16'h0}.
- `IRWrite_C` out 1: IR load.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = exception vector.
- `AluOp` out 3: 000 = pass A, 001 = add, 010 = sub, 011 = and, 110 = xor.
- `AluSrcA` out 1: 0 = PC, 1 = A.
- `AluSrcB` out 2: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `AluOutWrite`, `MDRWrite`, `AWrite`, `BWrite`, `RegWrite_C` out 1: register load enables.
- `RegDst` out 1: 0 = rt, 1 = rd.
- `Halted` out 1: high in HALT.
- `Exception` out 1: high in EXC.
- `State` out 6: current state code.

## Operation
- Moore FSM. All outputs are a combinational decode of the state register, except `PCWrite` in BRANCH. Any output not listed for a state is 0.
- States and codes:
  - RESET(0): all 0 → FETCH.
  - FETCH(1): AluSrcB=01, AluOp=001 → FETCH_WAIT if MEM_LAT>0, else IR_WRITE.
  - FETCH_WAIT(2): same ALU outputs as FETCH; stays MEM_LAT cycles → IR_WRITE.
  - IR_WRITE(3): IRWrite_C=1, PCWrite=1, PCSource=00, AluSrcB=01, AluOp=001 → DECODE.
  - DECODE(4): AWrite=BWrite=1, AluSrcB=11, AluOp=001, AluOutWrite=1. Dispatches on OP/Funct.
  - R_EXEC(5): AluSrcA=1, AluSrcB=00, AluOutWrite=1; AluOp from Funct (20h→001, 22h→010, 24h→011, 26h→110) → R_WB.
  - R_WB(6): RegDst=1, RegWrite_C=1 → FETCH.
  - ADDR(7): AluSrcA=1, AluSrcB=10, AluOp=001, AluOutWrite=1 → MEM_RD (LW) or MEM_WR (SW).
  - MEM_RD(8): IorD=1 → LD_WAIT if MEM_LAT>0, else MDR_WR.
  - LD_WAIT(17): IorD=1 for MEM_LAT cycles → MDR_WR.
  - MDR_WR(9): IorD=1, MDRWrite=1 → LW_WB.
  - LW_WB(10): MemtoReg=01, RegWrite_C=1 → FETCH.
  - MEM_WR(11): IorD=1, wr=1 for exactly one cycle → FETCH.
  - BRANCH(12): AluSrcA=1, AluSrcB=00, AluOp=010, PCSource=01. PCWrite = Zero for BEQ, PCWrite = ~Zero for BNE → FETCH.
  - LUI_WB(13): MemtoReg=10, RegWrite_C=1 → FETCH.
  - JUMP(14): PCSource=10, PCWrite=1 → FETCH.
  - HALT(15): Halted=1; stays until reset.
  - EXC(16): see Configuration.
- DECODE dispatch:
  - OP 00h with Funct 20/22/24/26h → R_EXEC.
  - OP 00h with Funct 0Dh → HALT.
  - OP 00h with Funct 00h (NOP) → FETCH.
  - 23h/2Bh → ADDR.
  - 04h/05h → BRANCH.
  - 0Fh → LUI_WB.
  - 02h → JUMP.
  - Anything else is illegal.
- A single wait counter of width clog2(MEM_LAT+1) serves both wait states. It is loaded on entry and decremented each cycle; exit occurs when the count reaches 1.

## Timing
- Reset assertion forces State=0 and all outputs to 0 asynchronously, aborting mid-operation. An in-progress `wr` drops in the same cycle.
- After reset deasserts: one RESET cycle, then FETCH.
- Cycles per instruction, FETCH to next FETCH:
  - R-type: 5+MEM_LAT.
  - LW: 7+2·MEM_LAT.
  - SW: 5+MEM_LAT.
  - BEQ/BNE, J, LUI: 4+MEM_LAT.
  - NOP: 3+MEM_LAT.
- `Zero` is sampled combinationally in BRANCH only; a change in any other state has no effect.
- `State` tracks the state register with zero lag.

## Configuration
- `CTRL_EXCEPTION_EN` defined: an illegal OP/Funct in DECODE goes to EXC. EXC asserts PCSource=11, PCWrite=1 and Exception=1 for one cycle, then goes to FETCH.
- `CTRL_EXCEPTION_EN` undefined: an illegal encoding goes from DECODE to FETCH, behaving as NOP. EXC is unreachable, and `Exception` is tied 0 (port retained).

## Test plan
- MEM_LAT=2, ADD (OP 00h, Funct 20h) → State sequence 1,2,2,3,4,5,6,1; RegWrite_C=1 and RegDst=1 only in state 6; 7 cycles total.
- MEM_LAT=0, LW (OP 23h) → sequence 1,3,4,7,8,9,10,1; MemtoReg=01 in state 10; no visits to state 2 or 17.
- BEQ with Zero=1, then BNE with Zero=1 → PCWrite=1, PCSource=01 in state 12 for BEQ; PCWrite=0 for BNE.
- SW (OP 2Bh) with Reset pulsed low during state 11 → wr falls in the same cycle, State=0; after release, FETCH follows one cycle later.
- BREAK (OP 00h, Funct 0Dh) → State=15 and Halted=1 held for 100 cycles; OP/Funct changes are ignored.
- OP 3Fh with `CTRL_EXCEPTION_EN` defined → state 16 for one cycle with PCSource=11, PCWrite=1, Exception=1, then state 1. Without the macro → state 4 goes directly to 1 and Exception stays 0.
